// File: rtl/gate_lab_sequencer_if.sv
// rtl/gate_lab_sequencer_if.sv - control, status and gate-bank signals of the gate lab sequencer
interface gate_lab_sequencer_if;
   logic       ena;
   logic       start;
   logic       abort;
   logic       mode;
   logic [6:0] gate_y;
   logic       gate_a;
   logic       gate_b;
   logic [1:0] vec_idx;
   logic       busy;
   logic       done;
   logic       pass;
   logic [6:0] fail_mask;

   modport master (
      output ena, start, abort, mode, gate_y,
      input  gate_a, gate_b, vec_idx, busy, done, pass, fail_mask
   );

   modport slave (
      input  ena, start, abort, mode, gate_y,
      output gate_a, gate_b, vec_idx, busy, done, pass, fail_mask
   );
endinterface

// File: rtl/gate_lab_sequencer.sv
// rtl/gate_lab_sequencer.sv - sweeps the four A/B vectors over the gate bank and checks each response
module gate_lab_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   gate_lab_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       vec_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [6:0]       fail_q;

   logic             a;
   logic             b;
   logic [6:0]       expected;
   logic [6:0]       fail_d;

   always_comb begin
      a        = vec_q[0];
      b        = vec_q[1];
      expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
      fail_d   = fail_q | (bus.gate_y ^ expected);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= '0;
      end else if (bus.ena) begin
         done_q <= 1'b0;
         if (bus.abort && state_q != IDLE) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start && !bus.abort) begin
                     state_q <= DRIVE;
                     vec_q   <= '0;
                     cnt_q   <= '0;
                     fail_q  <= '0;
                     pass_q  <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
               DRIVE: begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) state_q <= CHECK;
               end
               CHECK: begin
                  fail_q <= fail_d;
                  if (vec_q != 2'd3) begin
                     vec_q   <= vec_q + 2'd1;
                     cnt_q   <= '0;
                     state_q <= DRIVE;
                  end else begin
                     vec_q   <= '0;
                     done_q  <= 1'b1;
                     pass_q  <= (fail_d == 7'd0);
                     state_q <= DONE;
                  end
               end
               DONE: begin
                  // The DONE cycle already drives vector 0, so a looping sweep keeps a 4*(SETTLE+1) period.
                  if (bus.mode) begin
                     cnt_q   <= CNT_W'(1);
                     state_q <= (CNT_LAST == '0) ? CHECK : DRIVE;
                  end else begin
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.gate_a    = vec_q[0];
   assign bus.gate_b    = vec_q[1];
   assign bus.vec_idx   = vec_q;
   assign bus.busy      = busy_q;
   // Masked by ena so a frozen DONE cycle cannot read as a second pulse.
   assign bus.done      = done_q & bus.ena;
   assign bus.pass      = pass_q;
   assign bus.fail_mask = fail_q;
endmodule

// File: tb/tb_gate_lab_sequencer.sv
// tb/tb_gate_lab_sequencer.sv - randomized self-checking bench for gate_lab_sequencer
module tb_gate_lab_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gate_lab_sequencer_if bus ();
   gate_lab_sequencer_if bus1 ();

   gate_lab_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   gate_lab_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   // Truth tables indexed by {b,a}: AND, OR, NOTA, NAND, NOR, XOR, XNOR
   localparam logic [3:0] TRUTH [7] = '{4'b1000, 4'b1110, 4'b0101, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

   logic [6:0] inj [4];
   logic [6:0] stuck0;
   logic [6:0] stuck1;
   logic [1:0] cur_v;
   logic [1:0] cur_v1;

   function automatic logic [6:0] good_y(input logic [1:0] v);
      logic [6:0] y;
      for (int g = 0; g < 7; g++) y[g] = TRUTH[g][v];
      return y;
   endfunction

   function automatic logic [6:0] model_fail();
      logic [6:0] m;
      m = '0;
      for (int v = 0; v < 4; v++)
         m |= good_y(2'(v)) ^ (((good_y(2'(v)) ^ inj[v]) & ~stuck0) | stuck1);
      return m;
   endfunction

   assign cur_v      = {bus.gate_b, bus.gate_a};
   assign bus.gate_y = ((good_y(cur_v) ^ inj[cur_v]) & ~stuck0) | stuck1;
   assign cur_v1      = {bus1.gate_b, bus1.gate_a};
   assign bus1.gate_y = good_y(cur_v1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_faults();
      for (int v = 0; v < 4; v++) inj[v] = '0;
      stuck0 = '0;
      stuck1 = '0;
   endtask

   task automatic start_sweep();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int k);
      k = 0;
      while (bus.done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++; if ({bus.gate_a, bus.gate_b, bus.vec_idx, bus.busy, bus.done} !== 6'd0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.gate_a, bus.gate_b, bus.vec_idx, bus.busy, bus.done}); end
      checks++; if ({bus.pass, bus.fail_mask} !== 8'd0) begin failures++; $display("FAIL reset_result got=%b exp=0", {bus.pass, bus.fail_mask}); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp=0", bus.busy); end
   endtask

   task automatic test_good_sweep();
      clear_faults();
      tick();
      start_sweep();
      for (int k = 1; k <= 22; k++) begin
         tick();
         checks++; if (bus.vec_idx !== ((k <= 20) ? 2'((k % 20) / 5) : 2'd0)) begin failures++; $display("FAIL good_vec k=%0d got=%0d exp=%0d", k, bus.vec_idx, (k <= 20) ? (k % 20) / 5 : 0); end
         checks++; if ({bus.gate_b, bus.gate_a} !== bus.vec_idx) begin failures++; $display("FAIL good_ab k=%0d ab=%b vec=%b", k, {bus.gate_b, bus.gate_a}, bus.vec_idx); end
         checks++; if (bus.done !== (k == 20)) begin failures++; $display("FAIL good_done k=%0d got=%b exp=%b", k, bus.done, k == 20); end
         checks++; if (bus.busy !== (k <= 20)) begin failures++; $display("FAIL good_busy k=%0d got=%b exp=%b", k, bus.busy, k <= 20); end
      end
      checks++; if (bus.pass !== 1'b1 || bus.fail_mask !== 7'd0) begin failures++; $display("FAIL good_verdict pass=%b mask=%b exp pass=1 mask=0", bus.pass, bus.fail_mask); end
   endtask

   task automatic test_xor_stuck();
      clear_faults();
      stuck0 = 7'b0100000;
      tick();
      start_sweep();
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 5) begin
            checks++; if (bus.fail_mask !== 7'd0) begin failures++; $display("FAIL xor_after_v0 got=%b exp=0", bus.fail_mask); end
         end
         if (k == 10) begin
            checks++; if (bus.fail_mask !== 7'b0100000) begin failures++; $display("FAIL xor_after_v1 got=%b exp=0100000", bus.fail_mask); end
         end
      end
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL xor_done got=%b exp=1", bus.done); end
      checks++; if (bus.fail_mask !== model_fail() || bus.fail_mask !== 7'b0100000) begin failures++; $display("FAIL xor_mask got=%b exp=%b", bus.fail_mask, model_fail()); end
      checks++; if (bus.pass !== 1'b0) begin failures++; $display("FAIL xor_pass got=%b exp=0", bus.pass); end
   endtask

   task automatic test_nota_then_clear();
      int k;
      clear_faults();
      inj[3] = 7'b0000100;
      tick();
      tick();
      start_sweep();
      wait_done(100, k);
      checks++; if (k !== 20) begin failures++; $display("FAIL nota_latency got=%0d exp=20", k); end
      checks++; if (bus.fail_mask !== 7'b0000100 || bus.pass !== 1'b0) begin failures++; $display("FAIL nota_mask mask=%b pass=%b exp mask=0000100 pass=0", bus.fail_mask, bus.pass); end
      clear_faults();
      tick();
      start_sweep();
      checks++; if (bus.fail_mask !== 7'd0 || bus.busy !== 1'b1) begin failures++; $display("FAIL restart_clear mask=%b busy=%b exp mask=0 busy=1", bus.fail_mask, bus.busy); end
      wait_done(100, k);
      checks++; if (bus.pass !== 1'b1 || bus.fail_mask !== 7'd0) begin failures++; $display("FAIL restart_verdict pass=%b mask=%b exp pass=1 mask=0", bus.pass, bus.fail_mask); end
   endtask

   task automatic test_continuous();
      clear_faults();
      tick();
      tick();
      bus.mode = 1'b1;
      start_sweep();
      for (int k = 1; k <= 85; k++) begin
         tick();
         if (k == 65) bus.mode = 1'b0;
         checks++; if (bus.done !== (k % 20 == 0 && k <= 80)) begin failures++; $display("FAIL cont_done k=%0d got=%b", k, bus.done); end
         checks++; if (bus.busy !== (k <= 80)) begin failures++; $display("FAIL cont_busy k=%0d got=%b exp=%b", k, bus.busy, k <= 80); end
         checks++; if (bus.vec_idx !== ((k <= 80) ? 2'((k % 20) / 5) : 2'd0)) begin failures++; $display("FAIL cont_vec k=%0d got=%0d", k, bus.vec_idx); end
      end
      bus.mode = 1'b0;
   endtask

   task automatic test_abort();
      int seen;
      clear_faults();
      inj[0] = 7'b0000001;
      tick();
      tick();
      start_sweep();
      for (int k = 1; k <= 12; k++) tick();
      checks++; if (bus.vec_idx !== 2'd2 || bus.fail_mask !== 7'b0000001) begin failures++; $display("FAIL abort_pre vec=%0d mask=%b exp vec=2 mask=0000001", bus.vec_idx, bus.fail_mask); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.vec_idx !== 2'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL abort_exit busy=%b vec=%0d done=%b exp 0,0,0", bus.busy, bus.vec_idx, bus.done); end
      checks++; if (bus.fail_mask !== 7'b0000001 || bus.pass !== 1'b0) begin failures++; $display("FAIL abort_keep mask=%b pass=%b exp mask=0000001 pass=0", bus.fail_mask, bus.pass); end
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL abort_quiet active_cycles=%0d exp=0", seen); end
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_abort_idle busy=%b exp=0", bus.busy); end
   endtask

   task automatic test_ena_freeze();
      int k;
      logic [1:0] held;
      bit seen;
      clear_faults();
      tick();
      start_sweep();
      k = 0;
      seen = 0;
      held = '0;
      while (!seen && k < 100) begin
         tick();
         k++;
         if (k == 7) begin
            bus.ena = 1'b0;
            held = bus.vec_idx;
         end
         if (k == 16) begin
            checks++; if (bus.vec_idx !== held || bus.busy !== 1'b1) begin failures++; $display("FAIL ena_hold vec=%0d exp=%0d busy=%b", bus.vec_idx, held, bus.busy); end
         end
         if (k == 17) bus.ena = 1'b1;
         if (bus.done === 1'b1) seen = 1;
      end
      bus.ena = 1'b1;
      checks++; if (k !== 30) begin failures++; $display("FAIL ena_stretch latency=%0d exp=30", k); end
   endtask

   task automatic test_reset_mid_check();
      clear_faults();
      inj[0] = 7'b0000001;
      tick();
      start_sweep();
      for (int k = 1; k <= 9; k++) tick();
      checks++; if (bus.fail_mask !== 7'b0000001 || bus.vec_idx !== 2'd1) begin failures++; $display("FAIL rst_pre mask=%b vec=%0d", bus.fail_mask, bus.vec_idx); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({bus.gate_a, bus.gate_b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.fail_mask} !== 13'd0) begin failures++; $display("FAIL rst_async got=%b exp=0", {bus.gate_a, bus.gate_b, bus.vec_idx, bus.busy, bus.done, bus.pass, bus.fail_mask}); end
      #2 rst_n = 1'b1;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_stay_idle busy=%b exp=0", bus.busy); end
   endtask

   task automatic test_settle1();
      bus1.mode  = 1'b1;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 11) bus1.mode = 1'b0;
         checks++; if (bus1.vec_idx !== ((k <= 16) ? 2'((k % 8) / 2) : 2'd0)) begin failures++; $display("FAIL s1_vec k=%0d got=%0d", k, bus1.vec_idx); end
         checks++; if (bus1.done !== (k % 8 == 0 && k <= 16)) begin failures++; $display("FAIL s1_done k=%0d got=%b", k, bus1.done); end
         checks++; if (bus1.busy !== (k <= 16)) begin failures++; $display("FAIL s1_busy k=%0d got=%b", k, bus1.busy); end
      end
      checks++; if (bus1.pass !== 1'b1 || bus1.fail_mask !== 7'd0) begin failures++; $display("FAIL s1_verdict pass=%b mask=%b", bus1.pass, bus1.fail_mask); end
   endtask

   task automatic test_random();
      int k;
      int stray;
      int gap;
      bit seen;
      for (int it = 0; it < 10; it++) begin
         clear_faults();
         for (int v = 0; v < 4; v++)
            if ($urandom_range(0, 2) == 0) inj[v] = 7'(1 << $urandom_range(0, 6));
         if ($urandom_range(0, 4) == 0) stuck1 = 7'(1 << $urandom_range(0, 6));
         gap = $urandom_range(1, 4);
         for (int g = 0; g < gap; g++) tick();
         stray = $urandom_range(2, 18);
         start_sweep();
         k = 0;
         seen = 0;
         while (!seen && k < 100) begin
            tick();
            k++;
            bus.start = (k == stray);
            if (bus.done === 1'b1) seen = 1;
         end
         bus.start = 1'b0;
         checks++; if (k !== 20) begin failures++; $display("FAIL rand_latency it=%0d got=%0d exp=20", it, k); end
         checks++; if (bus.fail_mask !== model_fail()) begin failures++; $display("FAIL rand_mask it=%0d got=%b exp=%b", it, bus.fail_mask, model_fail()); end
         checks++; if (bus.pass !== (model_fail() == 7'd0)) begin failures++; $display("FAIL rand_pass it=%0d got=%b exp=%b", it, bus.pass, model_fail() == 7'd0); end
         tick();
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.ena    = 1'b1;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.mode   = 1'b0;
      bus1.ena   = 1'b1;
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      bus1.mode  = 1'b0;
      clear_faults();
      test_reset();
      test_good_sweep();
      test_xor_stuck();
      test_nota_then_clear();
      test_continuous();
      test_abort();
      test_ena_freeze();
      test_reset_mid_check();
      test_settle1();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gate_lab_sequencer.md
Name: gate_lab_sequencer

Overview:
- Self-test controller for the trainer's two-input gate bank (AND, OR, NOT-A, NAND, NOR, XOR, XNOR).
- On a start pulse it drives the four A/B input combinations onto the gate bank one after another. For each combination it waits a settle time, samples the seven gate outputs and checks them against an internal golden model.
- Reports per-gate sticky error flags and a pass/fail verdict.
- Sits between the top-level pin mux and the gate bank; when idle, the top level routes manual pins instead.

Parameters:
- SETTLE_CYCLES, 4, DRIVE cycles per vector before compare; legal range 1..255.
- CNT_W, 8, settle counter width; must hold SETTLE_CYCLES-1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; when 0, all state, counters and outputs freeze.
- start  in  1  sweep request, sampled in IDLE only.
- abort  in  1  synchronous abort of a running sweep.
- mode  in  1  0 = single sweep; 1 = continuous sweeps.
- gate_y  in  7  gate bank response; bit0 AND, bit1 OR, bit2 NOTA, bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.
- gate_a  out  1  A operand to the gate bank.
- gate_b  out  1  B operand to the gate bank.
- vec_idx  out  2  current vector index; gate_a = vec_idx[0], gate_b = vec_idx[1].
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at the end of each sweep.
- pass  out  1  verdict of the last completed sweep.
- fail_mask  out  7  sticky per-gate mismatch flags, same bit order as gate_y.

Behaviour:
Reset (async, rst_n=0):
- State IDLE.
- gate_a=0, gate_b=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=0, settle counter=0.
- Reset asserted mid-sweep aborts immediately to these values.

ena=0: no state change, outputs held, start/abort ignored; done never stretches beyond one enabled cycle.

States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - start=1 and abort=0 -> DRIVE.
  - On that transition: vec_idx=0, fail_mask cleared, pass cleared, busy=1, settle counter=0.
  - start and abort both high in IDLE: stay IDLE (abort wins).
- DRIVE:
  - Settle counter increments each cycle.
  - After SETTLE_CYCLES cycles in DRIVE -> CHECK.
- CHECK (1 cycle):
  - gate_y is compared against the expected values for a=vec_idx[0], b=vec_idx[1]:
    - AND = a&b, OR = a|b, NOTA = ~a, NAND = ~(a&b), NOR = ~(a|b), XOR = a^b, XNOR = ~(a^b).
  - fail_mask |= gate_y ^ expected.
  - vec_idx<3: vec_idx+1, counter=0 -> DRIVE.
  - vec_idx==3 -> DONE.
- DONE (1 cycle):
  - done=1; pass = (final fail_mask==0), including the CHECK-cycle update.
  - mode=1 sampled here: vec_idx wraps to 0, busy stays 1, fail_mask not cleared -> DRIVE.
  - Otherwise: busy=0 -> IDLE; vec_idx returns to 0.

Timing:
- Each vector is held for exactly SETTLE_CYCLES+1 cycles.
- With start sampled at edge T0, done is high in the cycle following edge T0 + 4*(SETTLE_CYCLES+1).
- gate_a/gate_b are registered outputs with no combinational path from inputs.

Boundary conditions:
- start while busy: ignored.
- abort in DRIVE, CHECK or DONE -> IDLE next cycle:
  - busy=0, no done pulse, vec_idx=0.
  - fail_mask and pass are retained as-is.
  - Abort wins over a same-cycle CHECK update.
- mode dropped mid-loop: the current sweep completes; exit at the next DONE.
- SETTLE_CYCLES=1: each vector is held 2 cycles.

Test Plan:
- Good gate bank model, SETTLE_CYCLES=4, mode=0, start at T0:
  - vec_idx steps 0,1,2,3 every 5 cycles.
  - done pulses once, 20 cycles after T0; pass=1, fail_mask=0, busy=0.
- Bench injects XOR stuck-at-0:
  - Mismatches at vectors 1 and 2.
  - Result: fail_mask=7'b0100000, pass=0.
- Bench injects NOTA inverted on vector 3 only: fail_mask=7'b0000100 after the sweep. A second start with a good model clears it -> pass=1.
- mode=1 for 3 sweeps, then mode=0:
  - done pulses every 20 cycles; busy stays high throughout; vec_idx wraps 3->0.
  - Exit after the sweep in progress when mode dropped.
- abort asserted mid-DRIVE of vector 2: next cycle busy=0, vec_idx=0, no done pulse, fail_mask unchanged. start with abort=1 in IDLE keeps IDLE.
- rst_n pulsed low mid-CHECK: all outputs zero immediately (asynchronous). ena=0 for 10 cycles mid-sweep stretches the total sweep time by exactly 10 cycles.
